// File: rtl/ldpc_wb_ctrl.sv
// rtl/ldpc_wb_ctrl.sv - Wishbone classic register front-end and run sequencer for an LDPC encode/decode core
module ldpc_wb_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          CW_BITS     = 128,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic               core_start_o,
    output logic               core_mode_o,
    output logic [CW_BITS-1:0] core_din_o,
    input  logic               core_done_i,
    input  logic               core_err_i,
    input  logic [CW_BITS-1:0] core_dout_i,
    output logic [2:0]         irq_o
);

    localparam int          NW       = CW_BITS / 32;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0] TMO_CYC  = 16'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t state, state_n;

    logic [31:0]        off;
    logic               req, wr, rd;
    logic [7:0]         widx;
    logic [5:0]         bidx;
    logic               in_din, in_dout;
    logic [31:0]        rdata;
    logic [2:0]         clr;
    logic               busy, done_evt, tmo_evt, start_req;
    logic               st_done, st_err, st_tmo;
    logic [2:0]         irq_en;
    logic [15:0]        cycles, run_cnt, cnt_inc;
    logic [CW_BITS-1:0] din, dout;

    // Subtracting the base makes addresses below the window wrap to huge offsets.
    assign off     = wbs_adr_i - BASE_ADDR;
    assign req     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & (off < 32'h400);
    assign wr      = req & wbs_we_i;
    assign rd      = req & ~wbs_we_i;
    assign widx    = off[9:2];
    assign bidx    = off[7:2];
    assign in_din  = (off[9:8] == 2'b01);
    assign in_dout = (off[9:8] == 2'b10);

    assign start_req  = wr & (widx == 8'h00) & wbs_sel_i[0] & wbs_dat_i[0];
    assign clr        = (wr && widx == 8'h01) ? wbs_dat_i[3:1] : 3'b000;
    assign cnt_inc    = (run_cnt == 16'hFFFF) ? run_cnt : run_cnt + 16'd1;
    assign core_din_o = din;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n      = state;
        core_start_o = 1'b0;
        busy         = 1'b0;
        done_evt     = 1'b0;
        tmo_evt      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_req) state_n = S_START;
            end
            S_START: begin
                core_start_o = 1'b1;
                busy         = 1'b1;
                state_n      = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                // A completion on the final allowed cycle beats the timeout.
                if (core_done_i) begin
                    done_evt = 1'b1;
                    state_n  = S_IDLE;
                end else if (run_cnt == TMO_LAST) begin
                    tmo_evt = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        rdata = 32'h0;
        if (in_din) begin
            for (int k = 0; k < NW; k++)
                if (bidx == 6'(k)) rdata = din[k*32 +: 32];
        end else if (in_dout) begin
            for (int k = 0; k < NW; k++)
                if (bidx == 6'(k)) rdata = dout[k*32 +: 32];
        end else begin
            case (widx)
                8'h00:   rdata = {30'b0, core_mode_o, 1'b0};
                8'h01:   rdata = {28'b0, st_tmo, st_err, st_done, busy};
                8'h02:   rdata = {29'b0, irq_en};
                8'h03:   rdata = {16'b0, cycles};
                default: rdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= 32'h0;
            core_mode_o <= 1'b0;
            irq_en      <= 3'b000;
            irq_o       <= 3'b000;
            st_done     <= 1'b0;
            st_err      <= 1'b0;
            st_tmo      <= 1'b0;
            cycles      <= 16'h0;
            run_cnt     <= 16'h0;
            din         <= '0;
            dout        <= '0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= rd ? rdata : 32'h0;

            if (wr && widx == 8'h00 && wbs_sel_i[0] && !busy) core_mode_o <= wbs_dat_i[1];
            if (wr && widx == 8'h02 && wbs_sel_i[0])          irq_en      <= wbs_dat_i[2:0];

            if (wr && in_din && !busy) begin
                for (int k = 0; k < NW; k++)
                    for (int b = 0; b < 4; b++)
                        if (bidx == 6'(k) && wbs_sel_i[b])
                            din[k*32 + b*8 +: 8] <= wbs_dat_i[b*8 +: 8];
            end

            if (state == S_START)                          run_cnt <= 16'h0;
            else if (state == S_RUN && run_cnt != 16'hFFFF) run_cnt <= run_cnt + 16'd1;

            if (done_evt) begin
                dout   <= core_dout_i;
                cycles <= cnt_inc;
            end else if (tmo_evt) begin
                cycles <= TMO_CYC;
            end

            // Sticky flags: a new event in the same cycle as a clear keeps the flag set.
            st_done <= (st_done & ~clr[0]) | done_evt;
            st_err  <= (st_err  & ~clr[1]) | (done_evt & core_err_i);
            st_tmo  <= (st_tmo  & ~clr[2]) | tmo_evt;

            irq_o <= {st_tmo, st_err, st_done} & irq_en;
        end
    end

endmodule
